ldtu_encoder_param: RTL
=======================

// Module: ldtu_encoder_param
// PURPOSE
//  Parametrised LiTe-DTU stream encoder. Packs gain-selected samples into 32-bit words: baseline
//  runs, signal pairs, orbit headers, and fallback raw pairs. Words go to an internal output FIFO
//  with a valid/ready interface toward the serialiser. The FSM is built in (no external FSM).
// PARAMETERS
//  NB_BAS      6  baseline sample width; BPW = 30/NB_BAS samples per full word; need 6+(BPW-1)*NB_BAS<=30
//  NB_SIG      13 signal sample width (<=13); samples zero-extended to 13-bit fields
//  FIFO_DEPTH  8  output FIFO words, power of 2, >=2
// PORTS
//  CLK        in   1       LiTe-DTU clock
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       sample strobe; no back-pressure on input
//  in_data    in   NB_SIG  sample
//  in_bas     in   1       1: sample is baseline (uses in_data[NB_BAS-1:0])
//  orbit      in   1       BC0: close pending data, append header word
//  flush      in   1       close pending data, no header
//  fallback   in   1       1: fallback raw-pair mode
//  out_data   out  32      FIFO head word; 0 when out_valid=0
//  out_valid  out  1       FIFO non-empty
//  out_ready  in   1       pop when out_valid&out_ready
//  overflow   out  1       sticky: a word was dropped
// BEHAVIOUR
//  Word formats (samples oldest at LSB):
//   FULL_BAS {2'b01, pad0, BPW samples}; PART_BAS {2'b10, k[5:0], pad0, k samples}, k=1..BPW-1
//   SIG_PAIR {6'b001010, newer13, older13}; SIG_ONE {6'b001011, 13'b0101010101010, s13}
//   HEADER {6'b001011, 13'b1111000001111, 13'b0}; FB {4'b1111, ~^newer, ~^older, newer13, older13}
//  States: IDLE, BAS(k), SIG (one held), FB_ODD, FB_EVEN; all actions on in_valid=1 only.
//   IDLE: bas -> BAS(1); !bas -> SIG.
//   BAS(k): bas -> store; k+1==BPW writes FULL_BAS, -> IDLE; else BAS(k+1).
//           !bas -> write PART_BAS(k), hold sample, -> SIG.
//   SIG: !bas -> write SIG_PAIR, -> IDLE; bas -> write SIG_ONE, -> BAS(1) with sample.
//   FB_ODD: hold sample -> FB_EVEN; FB_EVEN: write FB -> FB_ODD.
//  orbit (priority over flush): same cycle write close word (PART_BAS/SIG_ONE if pending), then
//   HEADER; a sample valid that cycle becomes the first of a new group (BAS(1)/SIG). Both words
//   in one cycle (2-entry write); if space <2, both dropped. flush: close word only, no header.
//   orbit/flush ignored in fallback mode.
//  fallback change: pending data discarded; 0->1 -> FB_ODD, 1->0 -> IDLE; sample that cycle
//   is processed in the new mode.
//  FIFO: write at edge sampling the completing input; out_valid rises next cycle (latency 1).
//   Space check includes same-cycle pop. On no room: word dropped, overflow<=1 until reset.
//  reset: state IDLE, pending cleared, FIFO empty, out_valid=0, out_data=0, overflow=0;
//   mid-word reset discards pending samples; no word emitted.
// CONFIGURATION
//  LDTU_ENC_STATS_EN defined: adds outputs word_cnt[15:0] (FIFO writes, wraps) and
//   drop_cnt[15:0] (dropped words, saturates at 16'hFFFF); both 0 on reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (default parameters)
//  baseline 1,2,3,4,5 -> one word 0x45103081; out_valid one cycle after sample 5
//  baseline 7,9 then signal 0x1000, 0x0ABC -> 0x82000247 then 0x29579000
//  BAS(1) holding 3, orbit with baseline 4 -> 0x81000003, 0x2FC1E000; state BAS(1) holding 4
//  fallback=1, samples 0x0001, 0x0003 -> 0xF8006001
//  out_ready=0, 45 baseline samples (9 words) -> 8 held, overflow=1; out_ready=1 drains 8 in order
//  reset with 3 baseline pending -> no word, out_valid=0, overflow=0 after reset

Source files
------------

// File: rtl/ldtu_encoder_param.sv
// rtl/ldtu_encoder_param.sv - LiTe-DTU stream encoder: baseline/signal/fallback packing into an output FIFO
// Optional LDTU_ENC_STATS_EN adds word_cnt/drop_cnt statistics outputs.
module ldtu_encoder_param #(
  parameter int NB_BAS     = 6,
  parameter int NB_SIG     = 13,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [NB_SIG-1:0] in_data,
  input  logic              in_bas,
  input  logic              orbit,
  input  logic              flush,
  input  logic              fallback,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
`ifdef LDTU_ENC_STATS_EN
  ,
  output logic [15:0]       word_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int BPW = 30 / NB_BAS;
  localparam int BW  = (BPW - 1) * NB_BAS;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [5:0]    BPW_W = 6'(BPW);
  localparam logic [AW-1:0] P1    = AW'(1);
  localparam logic [31:0]   HDR   = {6'b001011, 13'b1111000001111, 13'b0};

  typedef enum logic [2:0] {S_IDLE, S_BAS, S_SIG, S_FB_ODD, S_FB_EVEN} state_t;

  state_t          state, nx_state;
  logic [5:0]      bas_cnt, nx_cnt;
  logic [BW-1:0]   bas_buf, nx_buf;
  logic [12:0]     sig_hold, nx_sig;
  logic            fb_q;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic [1:0]      n_wr;
  logic [31:0]     w0, w1;
  logic            pop, accept;
  logic [AW+1:0]   free;
  logic [AW:0]     wr_cnt, pop_cnt;

  logic [12:0]       s13;
  logic [NB_BAS-1:0] b6;
  assign s13 = 13'(in_data);
  assign b6  = in_data[NB_BAS-1:0];

  function automatic logic [31:0] part_word(input logic [5:0] k, input logic [BW-1:0] b);
    return {2'b10, k, 24'(b)};
  endfunction

  function automatic logic [31:0] sig_one(input logic [12:0] s);
    return {6'b001011, 13'b0101010101010, s};
  endfunction

  // Decode this cycle's action: close/header words first, then the sample in the (possibly new) state.
  always_comb begin
    state_t st;
    st       = state;
    nx_cnt   = bas_cnt;
    nx_buf   = bas_buf;
    nx_sig   = sig_hold;
    n_wr     = 2'd0;
    w0       = 32'h0;
    w1       = 32'h0;

    if (fallback != fb_q) st = fallback ? S_FB_ODD : S_IDLE;

    if (!fallback && (orbit || flush)) begin
      if (st == S_BAS) begin
        w0   = part_word(bas_cnt, bas_buf);
        n_wr = 2'd1;
      end else if (st == S_SIG) begin
        w0   = sig_one(sig_hold);
        n_wr = 2'd1;
      end
      if (orbit) begin
        if (n_wr == 2'd1) w1 = HDR;
        else              w0 = HDR;
        n_wr = n_wr + 2'd1;
      end
      st = S_IDLE;
    end

    nx_state = st;
    if (in_valid) begin
      case (st)
        S_IDLE: begin
          if (in_bas) begin
            nx_state = S_BAS;
            nx_cnt   = 6'd1;
            nx_buf   = BW'(b6);
          end else begin
            nx_state = S_SIG;
            nx_sig   = s13;
          end
        end
        S_BAS: begin
          if (in_bas) begin
            if (bas_cnt + 6'd1 == BPW_W) begin
              w0       = {2'b01, 30'({b6, bas_buf})};
              n_wr     = 2'd1;
              nx_state = S_IDLE;
            end else begin
              for (int i = 0; i < BPW - 1; i++)
                if (bas_cnt == 6'(i)) nx_buf[i*NB_BAS +: NB_BAS] = b6;
              nx_cnt = bas_cnt + 6'd1;
            end
          end else begin
            w0       = part_word(bas_cnt, bas_buf);
            n_wr     = 2'd1;
            nx_sig   = s13;
            nx_state = S_SIG;
          end
        end
        S_SIG: begin
          if (in_bas) begin
            w0       = sig_one(sig_hold);
            n_wr     = 2'd1;
            nx_cnt   = 6'd1;
            nx_buf   = BW'(b6);
            nx_state = S_BAS;
          end else begin
            w0       = {6'b001010, s13, sig_hold};
            n_wr     = 2'd1;
            nx_state = S_IDLE;
          end
        end
        S_FB_ODD: begin
          nx_sig   = s13;
          nx_state = S_FB_EVEN;
        end
        default: begin
          w0       = {4'b1111, ~^s13, ~^sig_hold, s13, sig_hold};
          n_wr     = 2'd1;
          nx_state = S_FB_ODD;
        end
      endcase
    end
  end

  // Free space counts a pop in the same cycle; a double write needs two free slots or both drop.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;
  assign pop       = out_valid & out_ready;
  assign free      = (AW+2)'(FIFO_DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
  assign accept    = (n_wr != 2'd0) && (free >= (AW+2)'(n_wr));
  assign wr_cnt    = accept ? (AW+1)'(n_wr) : '0;
  assign pop_cnt   = (AW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[wr_ptr] <= w0;
      if (n_wr == 2'd2) mem[wr_ptr + P1] <= w1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      bas_cnt  <= '0;
      bas_buf  <= '0;
      sig_hold <= '0;
      fb_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef LDTU_ENC_STATS_EN
      word_cnt <= '0;
      drop_cnt <= '0;
`endif
    end else begin
      state    <= nx_state;
      bas_cnt  <= nx_cnt;
      bas_buf  <= nx_buf;
      sig_hold <= nx_sig;
      fb_q     <= fallback;
      if (pop) rd_ptr <= rd_ptr + P1;
      if (accept) wr_ptr <= wr_ptr + AW'(n_wr);
      if (n_wr != 2'd0 && !accept) overflow <= 1'b1;
      count <= count + wr_cnt - pop_cnt;
`ifdef LDTU_ENC_STATS_EN
      word_cnt <= word_cnt + 16'(wr_cnt);
      if (n_wr != 2'd0 && !accept)
        drop_cnt <= (drop_cnt > 16'hFFFF - 16'(n_wr)) ? 16'hFFFF : drop_cnt + 16'(n_wr);
`endif
    end
  end

endmodule
